// File: rtl/cache_dfp_arbiter.sv
// cache_dfp_arbiter
// Shares one downstream memory port between the instruction cache and the
// data cache. Round-robin grant, registered memory-side strobes/address/data,
// combinational response routing back to the owner, and a sticky watchdog
// that flags memory transactions which never complete.

module cache_dfp_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] i_dfp_addr,
    input  logic              i_dfp_read,
    output logic [LINE_W-1:0] i_dfp_rdata,
    output logic              i_dfp_resp,

    input  logic [ADDR_W-1:0] d_dfp_addr,
    input  logic              d_dfp_read,
    input  logic              d_dfp_write,
    input  logic [LINE_W-1:0] d_dfp_wdata,
    output logic [LINE_W-1:0] d_dfp_rdata,
    output logic              d_dfp_resp,

    output logic [ADDR_W-1:0] dfp_addr,
    output logic              dfp_read,
    output logic              dfp_write,
    output logic [LINE_W-1:0] dfp_wdata,
    input  logic [LINE_W-1:0] dfp_rdata,
    input  logic              dfp_resp,
    output logic              dfp_timeout
);

    // Counter only has to reach TIMEOUT-1, where it saturates.
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WD_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Requester identity used by owner and last_grant.
    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

    state_t            state_r;
    logic              owner_r;
    logic              last_grant_r;
    logic [ADDR_W-1:0] addr_r;
    logic [LINE_W-1:0] wdata_r;
    logic              read_r;
    logic              write_r;
    logic [CNT_W-1:0]  wd_cnt_r;
    logic              timeout_r;

    logic              i_req_s;
    logic              d_req_s;
    logic              grant_i_s;
    logic              grant_d_s;
    logic              resp_hit_s;

    assign i_req_s = i_dfp_read;
    assign d_req_s = d_dfp_read | d_dfp_write;

    // Round-robin pick: on a tie the requester that was not served last wins.
    always_comb begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        if (i_req_s && d_req_s) begin
            if (last_grant_r == SEL_D) begin
                grant_i_s = 1'b1;
            end else begin
                grant_d_s = 1'b1;
            end
        end else if (i_req_s) begin
            grant_i_s = 1'b1;
        end else if (d_req_s) begin
            grant_d_s = 1'b1;
        end else begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
        end
    end

    // Memory completion only counts while a transaction is outstanding and not
    // during reset, so idle or late responses never reach a cache.
    assign resp_hit_s = (state_r == BUSY) && dfp_resp && !rst;

    // Route the completion pulse to whichever cache owns the transaction.
    always_comb begin
        i_dfp_resp = 1'b0;
        d_dfp_resp = 1'b0;
        if (resp_hit_s) begin
            if (owner_r == SEL_I) begin
                i_dfp_resp = 1'b1;
            end else begin
                d_dfp_resp = 1'b1;
            end
        end else begin
            i_dfp_resp = 1'b0;
            d_dfp_resp = 1'b0;
        end
    end

    // Arbitration FSM: latch the granted request, hold it until dfp_resp,
    // and run the watchdog while waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            owner_r      <= SEL_I;
            last_grant_r <= SEL_D;
            addr_r       <= '0;
            wdata_r      <= '0;
            read_r       <= 1'b0;
            write_r      <= 1'b0;
            wd_cnt_r     <= '0;
            timeout_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    wd_cnt_r <= '0;
                    if (grant_i_s) begin
                        state_r      <= BUSY;
                        owner_r      <= SEL_I;
                        last_grant_r <= SEL_I;
                        addr_r       <= i_dfp_addr;
                        wdata_r      <= '0;
                        read_r       <= 1'b1;
                        write_r      <= 1'b0;
                    end else if (grant_d_s) begin
                        state_r      <= BUSY;
                        owner_r      <= SEL_D;
                        last_grant_r <= SEL_D;
                        addr_r       <= d_dfp_addr;
                        wdata_r      <= d_dfp_wdata;
                        // A simultaneous read+write resolves as a write.
                        read_r       <= d_dfp_read & ~d_dfp_write;
                        write_r      <= d_dfp_write;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (dfp_resp) begin
                        state_r  <= IDLE;
                        read_r   <= 1'b0;
                        write_r  <= 1'b0;
                        wd_cnt_r <= '0;
                    end else begin
                        if (wd_cnt_r != WD_MAX) begin
                            wd_cnt_r <= wd_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            timeout_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    read_r  <= 1'b0;
                    write_r <= 1'b0;
                end
            endcase
        end
    end

    assign dfp_addr    = addr_r;
    assign dfp_wdata   = wdata_r;
    assign dfp_read    = read_r;
    assign dfp_write   = write_r;
    assign dfp_timeout = timeout_r;

    // Caches qualify the shared read data with their own resp.
    assign i_dfp_rdata = dfp_rdata;
    assign d_dfp_rdata = dfp_rdata;

    cache_dfp_arbiter_checker u_checker (
        .clk         (clk),
        .rst         (rst),
        .d_dfp_read  (d_dfp_read),
        .d_dfp_write (d_dfp_write)
    );

endmodule

// Protocol checks on the arbiter's upstream interface.
module cache_dfp_arbiter_checker (
    input logic clk,
    input logic rst,
    input logic d_dfp_read,
    input logic d_dfp_write
);

    // The data cache must never request a read and a writeback together.
    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(d_dfp_read && d_dfp_write));

endmodule

// File: doc/cache_dfp_arbiter.md
Name: cache_dfp_arbiter

Overview:
Shares the single downstream memory port (DFP) between the instruction cache and the data cache. Each cache holds its DFP request level-high until it receives a one-cycle response. The arbiter grants one requester at a time using round-robin. It latches the granted request and drives the memory side from registers, then routes the response back to the owner. A watchdog flags memory transactions that never complete.

Parameters:
ADDR_W, 32, DFP address width (line-aligned byte address)
LINE_W, 256, cache line width in bits
TIMEOUT, 1024, cycles in BUSY without dfp_resp before dfp_timeout sets; must be >= 2

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous active-high reset
i_dfp_addr  input  ADDR_W  icache line address
i_dfp_read  input  1  icache read request; held until i_dfp_resp
i_dfp_rdata  output  LINE_W  read line to icache
i_dfp_resp  output  1  one-cycle completion pulse to icache
d_dfp_addr  input  ADDR_W  dcache line address
d_dfp_read  input  1  dcache read request; held until d_dfp_resp
d_dfp_write  input  1  dcache writeback request; held until d_dfp_resp
d_dfp_wdata  input  LINE_W  dcache writeback line
d_dfp_rdata  output  LINE_W  read line to dcache
d_dfp_resp  output  1  one-cycle completion pulse to dcache
dfp_addr  output  ADDR_W  memory address (registered)
dfp_read  output  1  memory read strobe, level until dfp_resp
dfp_write  output  1  memory write strobe, level until dfp_resp
dfp_wdata  output  LINE_W  memory write data (registered)
dfp_rdata  input  LINE_W  memory read data, valid with dfp_resp
dfp_resp  input  1  memory completion pulse
dfp_timeout  output  1  sticky watchdog error flag

Behaviour:
- States: IDLE, BUSY. Registers: owner (I/D), last_grant (I/D), addr_q, wdata_q, read_q, write_q, wd_cnt, dfp_timeout.
- Reset state: IDLE; last_grant = D (so icache wins the first tie); dfp_read = dfp_write = 0; i_dfp_resp = d_dfp_resp = 0; dfp_timeout = 0; wd_cnt = 0; addr_q and wdata_q = 0.
- IDLE:
  - Request sampling: i_req = i_dfp_read; d_req = d_dfp_read | d_dfp_write.
  - If only one requester is active, grant it. If both are active, grant the one that is not last_grant.
  - On grant at posedge: owner and last_grant take the granted requester; addr_q, read_q, write_q and wdata_q latch that requester's inputs; wdata_q = 0 for an icache grant; next state is BUSY.
  - dfp_read and dfp_write are 0 in IDLE. dfp_resp in IDLE is ignored and produces no upstream resp.
- BUSY:
  - dfp_read = read_q, dfp_write = write_q, dfp_addr = addr_q, dfp_wdata = wdata_q. All are stable for the whole transaction regardless of input changes.
  - On dfp_resp, in the same cycle (combinational): the owner's resp = 1 and the other requester's resp = 0; next state is IDLE; wd_cnt clears.
  - Without dfp_resp: wd_cnt increments, saturating. When wd_cnt reaches TIMEOUT-1, dfp_timeout sets and stays set until rst. The arbiter keeps waiting in BUSY.
- i_dfp_rdata and d_dfp_rdata are both driven directly from dfp_rdata; requesters qualify them with their own resp.
- Latency:
  - Request first seen high in IDLE at cycle N: memory strobe high at N+1. Response at cycle M reaches the requester at M.
  - After resp the state is IDLE at M+1, so there is a minimum of 1 dead cycle between transactions. The next grant's strobe appears at M+2.
- A requester must drop its request in the cycle after resp. A request still high in IDLE is treated as a new request.
- A requester that deasserts its request while the other is being served loses nothing. Its request is simply not seen.
- d_dfp_read and d_dfp_write high together is illegal and is covered by an assertion. If it occurs, write wins (read_q = 0).
- Reset mid-BUSY: the next cycle is IDLE with strobes 0 and no resp issued. A late dfp_resp is ignored.

Test Plan:
- Single icache read, addr 0x0000_1000, memory responds 3 cycles after strobe with line 0xA5 repeated -> dfp_read high for exactly 4 cycles starting 1 cycle after request; i_dfp_resp pulses once with rdata 0xA5..A5; d_dfp_resp stays 0.
- Both caches request in the same IDLE cycle immediately after reset (i read 0x100, d write 0x200, wdata 0x1234) -> icache granted first; after its resp and 1 idle cycle, dfp_write high with addr 0x200 and wdata 0x1234.
- Both hold requests continuously for 6 transactions, each cache dropping its request for one cycle after each resp -> grants alternate I, D, I, D, I, D.
- Dcache changes d_dfp_addr mid-transaction from 0x200 to 0x300 -> dfp_addr stays 0x200 until dfp_resp.
- Memory never responds, TIMEOUT=16 -> dfp_timeout rises after 16 BUSY cycles and stays 1; rst clears it, returns to IDLE, and a late dfp_resp produces no upstream resp.
- dfp_resp asserted while IDLE -> i_dfp_resp = d_dfp_resp = 0 and state unchanged.
